// File: rtl/iq_mod_pkg.sv
// Shared widths, limits and types for the IQ polar modulator slice.
// The cosine table contents are generated from cos_entry at elaboration.
package iq_mod_pkg;

    localparam int unsigned LUT_DEPTH = 1024;
    localparam int unsigned LUT_AW    = 10;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned ACC_W     = 32;
    localparam int          SAT_LIM   = 32767;
    localparam real         PI        = 3.14159265358979323846;

    typedef logic signed [DATA_W-1:0] sample_t;

    typedef struct packed {
        logic [DATA_W-1:0] mag;
        logic [DATA_W-1:0] ph;
    } iq_sample_t;

    typedef enum logic {
        ST_WAIT_FIRST,
        ST_RUN
    } run_state_t;

    // round(SAT_LIM * cos(2*pi*k/LUT_DEPTH)), half away from zero
    function automatic sample_t cos_entry(input int unsigned k);
        real ang;
        real v;
        ang = 2.0 * PI * real'(k) / real'(LUT_DEPTH);
        v   = real'(SAT_LIM) * $cos(ang);
        if (v >= 0.0) v = v + 0.5;
        else          v = v - 0.5;
        return sample_t'($rtoi(v));
    endfunction

endpackage

// File: rtl/iq_mod_cos_lut.sv
// Full-wave cosine ROM, signed Q1.15, one clock of read latency.
module iq_mod_cos_lut
    import iq_mod_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LUT_AW-1:0] addr,
    output sample_t           cos_q
);

    sample_t rom [LUT_DEPTH];

    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
        localparam sample_t ENTRY = cos_entry(k);
        assign rom[k] = ENTRY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cos_q <= '0;
        else        cos_q <= rom[addr];
    end

endmodule

// File: rtl/iq_mod_top.sv
// Polar-to-carrier modulator: buffered sample hold, NCO, cosine LUT and
// scaled output, 4 clocks from active-sample update to dac_data.
module iq_mod_top
    import iq_mod_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 50
) (
    input  logic              sys_clk,
    input  logic              sys_rstn,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] magni,
    input  logic signed [DATA_W-1:0] phase,
    input  logic [ACC_W-1:0]  cw_phase_increment,
    input  logic              cw_phase_increment_valid,
    output logic signed [DATA_W-1:0] dac_data,
    output logic              dac_valid,
    output logic              underrun
);

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam int unsigned PW        = 2 * DATA_W + 1;
    localparam logic signed [PW-1:0] SAT_HI = PW'(SAT_LIM);
    localparam logic signed [PW-1:0] SAT_LO = -SAT_HI;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] tw;
    iq_sample_t       buf_s;
    iq_sample_t       act_s;
    logic             buf_full;
    logic             buf_full_nxt;
    logic             take;
    logic             load;
    run_state_t       state;
    logic [15:0]      hold_cnt;

    assign take = s_valid && s_ready;
    assign load = buf_full && ((state == ST_WAIT_FIRST) || (hold_cnt == '0));

    always_comb begin
        buf_full_nxt = buf_full;
        if (load) buf_full_nxt = 1'b0;
        if (take) buf_full_nxt = 1'b1;
    end

    // Expiry looks at the pre-edge buffer, so a sample arriving on the
    // expiry edge of an empty buffer still underruns and waits one period.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            acc      <= '0;
            tw       <= '0;
            buf_s    <= '0;
            act_s    <= '0;
            buf_full <= 1'b0;
            s_ready  <= 1'b0;
            state    <= ST_WAIT_FIRST;
            hold_cnt <= '0;
            underrun <= 1'b0;
        end else begin
            acc      <= acc + tw;
            underrun <= 1'b0;
            if (cw_phase_increment_valid) tw <= cw_phase_increment;

            case (state)
                ST_WAIT_FIRST: begin
                    if (buf_full) begin
                        act_s    <= buf_s;
                        state    <= ST_RUN;
                        hold_cnt <= HOLD_LAST;
                    end
                end
                ST_RUN: begin
                    if (hold_cnt == '0) begin
                        hold_cnt <= HOLD_LAST;
                        if (buf_full) begin
                            act_s <= buf_s;
                        end else begin
                            act_s.mag <= '0;
                            underrun  <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 16'd1;
                    end
                end
            endcase

            if (take) buf_s <= {magni, phase};
            buf_full <= buf_full_nxt;
            s_ready  <= !buf_full_nxt;
        end
    end

    logic [DATA_W-1:0]   psum;
    logic [DATA_W-1:0]   mag1;
    logic [DATA_W-1:0]   mag2;
    logic                v1;
    logic                v2;
    logic                v3;
    sample_t             cos_q;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] cos_ext;
    logic signed [PW-1:0] mag_ext;
    logic signed [PW-1:0] rnd_sh;
    sample_t             sat_val;
    logic                unused_psum_lsb;

    assign unused_psum_lsb = ^psum[5:0];

    iq_mod_cos_lut u_cos_lut (
        .clk   (sys_clk),
        .rst_n (sys_rstn),
        .addr  (psum[DATA_W-1 -: LUT_AW]),
        .cos_q (cos_q)
    );

    assign cos_ext = PW'(cos_q);
    assign mag_ext = PW'(mag2);
    assign rnd_sh  = (prod + PW'(32768)) >>> 16;

    always_comb begin
        sat_val = rnd_sh[DATA_W-1:0];
        if (rnd_sh > SAT_HI)      sat_val = sample_t'(SAT_LIM);
        else if (rnd_sh < SAT_LO) sat_val = sample_t'(-SAT_LIM);
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            psum      <= '0;
            mag1      <= '0;
            mag2      <= '0;
            prod      <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            dac_data  <= '0;
            dac_valid <= 1'b0;
        end else begin
            psum      <= acc[ACC_W-1 -: DATA_W] + act_s.ph;
            mag1      <= act_s.mag;
            v1        <= (state == ST_RUN);
            mag2      <= mag1;
            v2        <= v1;
            prod      <= cos_ext * mag_ext;
            v3        <= v2;
            dac_data  <= sat_val;
            dac_valid <= v3;
        end
    end

endmodule

// File: tb/tb_iq_mod_top.sv
// Randomised bench for iq_mod_top against a cycle-indexed reference model
// built from the sample-hold schedule and the carrier phase history.
module tb_iq_mod_top;

    localparam int unsigned HOLD = 4;
    localparam real PI = 3.14159265358979323846;

    logic               sys_clk = 1'b0;
    logic               sys_rstn;
    logic               s_valid;
    logic               s_ready;
    logic [15:0]        magni;
    logic signed [15:0] phase;
    logic [31:0]        cw_phase_increment;
    logic               cw_phase_increment_valid;
    logic signed [15:0] dac_data;
    logic               dac_valid;
    logic               underrun;

    iq_mod_top #(.HOLD_CYCLES(HOLD)) dut (
        .sys_clk                  (sys_clk),
        .sys_rstn                 (sys_rstn),
        .s_valid                  (s_valid),
        .s_ready                  (s_ready),
        .magni                    (magni),
        .phase                    (phase),
        .cw_phase_increment       (cw_phase_increment),
        .cw_phase_increment_valid (cw_phase_increment_valid),
        .dac_data                 (dac_data),
        .dac_valid                (dac_valid),
        .underrun                 (underrun)
    );

    always #10 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] mag;
        logic [15:0] ph;
    } samp_t;

    logic signed [15:0] cos_tab [1024];
    int unsigned cyc;
    int unsigned t_first;
    bit          started;
    bit          m_ready;
    logic [31:0] m_acc;
    logic [31:0] m_tw;
    samp_t       act;
    samp_t       pend [$];
    logic [31:0] h_acc [$];
    samp_t       h_act [$];
    int unsigned n_accept;
    int unsigned n_under;

    function automatic logic signed [63:0] expect_dac(input logic [31:0] a, input samp_t s);
        logic [15:0] ps;
        longint      p;
        ps = a[31:16] + s.ph;
        p  = longint'(cos_tab[ps[15:6]]) * longint'({48'd0, s.mag});
        p  = (p + 32768) >>> 16;
        if (p > 32767)  p = 32767;
        if (p < -32767) p = -32767;
        return p;
    endfunction

    task automatic model_reset();
        cyc = 0;
        t_first = 0;
        started = 0;
        m_ready = 0;
        m_acc = '0;
        m_tw = '0;
        act = '0;
        pend.delete();
        h_acc.delete();
        h_act.delete();
        h_acc.push_back('0);
        h_act.push_back('0);
    endtask

    // One clock: capture pre-edge inputs, advance the model, compare at edge+1.
    task automatic step();
        bit                 take;
        bit                 tw_ld;
        logic [31:0]        tw_val;
        samp_t              in_s;
        bit                 exp_under;
        logic signed [63:0] exp_dac;
        take   = s_valid && m_ready;
        tw_ld  = cw_phase_increment_valid;
        tw_val = cw_phase_increment;
        in_s   = {magni, phase};
        if (s_valid && s_ready) n_accept++;
        @(posedge sys_clk);
        #1;
        cyc++;
        exp_under = 0;
        m_acc = m_acc + m_tw;
        if (tw_ld) m_tw = tw_val;
        if (!started) begin
            if (pend.size() != 0) begin
                act = pend.pop_front();
                started = 1;
                t_first = cyc;
            end
        end else if ((cyc - t_first) % HOLD == 0) begin
            if (pend.size() != 0) act = pend.pop_front();
            else begin
                act.mag = '0;
                exp_under = 1;
            end
        end
        if (take) pend.push_back(in_s);
        m_ready = (pend.size() == 0);
        h_acc.push_back(m_acc);
        h_act.push_back(act);
        if (underrun) n_under++;
        exp_dac = (cyc >= 4) ? expect_dac(h_acc[cyc-4], h_act[cyc-4]) : 64'sd0;
        check("s_ready", s_ready, m_ready);
        check("underrun", underrun, exp_under);
        check("dac_valid", dac_valid, started && (cyc >= t_first + 4));
        check("dac_data", dac_data, exp_dac);
    endtask

    task automatic run(input int unsigned n);
        repeat (n) step();
    endtask

    task automatic drive(input bit v, input logic [15:0] m, input logic [15:0] p);
        s_valid = v;
        magni   = m;
        phase   = p;
    endtask

    task automatic set_k(input logic [31:0] k);
        cw_phase_increment       = k;
        cw_phase_increment_valid = 1'b1;
        step();
        cw_phase_increment_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_dac_data"}, dac_data, 0);
        check({tag, "_dac_valid"}, dac_valid, 0);
        check({tag, "_underrun"}, underrun, 0);
    endtask

    // Entered at edge+1; asserts reset mid-cycle and releases it mid-cycle.
    task automatic apply_reset();
        #4 sys_rstn = 1'b0;
        s_valid = 1'b0;
        cw_phase_increment_valid = 1'b0;
        #1 check_reset_outputs("rst_async");
        repeat (2) @(posedge sys_clk);
        #1 check_reset_outputs("rst_held");
        #4 sys_rstn = 1'b1;
        model_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 1024; k++) begin
            real v;
            v = 32767.0 * $cos(2.0 * PI * real'(k) / 1024.0);
            cos_tab[k] = 16'($rtoi((v >= 0.0) ? v + 0.5 : v - 0.5));
        end

        sys_rstn = 1'b0;
        cw_phase_increment = '0;
        cw_phase_increment_valid = 1'b0;
        drive(0, '0, '0);
        n_accept = 0;
        n_under = 0;
        #1 check_reset_outputs("rst_init");
        repeat (3) @(posedge sys_clk);
        #5 sys_rstn = 1'b1;
        model_reset();

        // steady full-scale carrier at DC, then inverted phase
        drive(1, 16'hFFFF, 16'h0000);
        set_k(32'h0);
        run(40);
        check("sc035_pos", dac_data, 32767);
        drive(1, 16'hFFFF, 16'h8000);
        n_accept = 0;
        n_under = 0;
        run(40);
        check("sc035_neg", dac_data, -32767);
        check("sc038_accepts", n_accept, 10);
        check("sc038_underruns", n_under, 0);

        drive(1, 16'd32768, 16'h4000);
        run(40);
        check("sc037_quadrature", dac_data, 0);
        drive(1, 16'd32768, 16'h0000);
        run(40);
        check("sc037_half", dac_data, 16384);

        drive(1, 16'hFFFF, 16'h0000);
        set_k(32'h4000_0000);
        run(40);
        set_k(32'h2000_0000);
        run(41);
        apply_reset();

        // lone sample followed by starvation
        drive(1, 16'hFFFF, 16'h0000);
        n_accept = 0;
        for (int i = 0; i < 20 && n_accept == 0; i++) step();
        check("sc039_accept", n_accept, 1);
        drive(0, 16'hFFFF, 16'h0000);
        n_under = 0;
        run(HOLD + 1);
        check("sc039_underrun_once", n_under, 1);
        run(4);
        check("sc039_dac_zero", dac_data, 0);

        for (int blk = 0; blk < 12; blk++) begin
            int unsigned pct;
            pct = (blk % 3 == 0) ? 25 : ((blk % 3 == 1) ? 70 : 100);
            for (int i = 0; i < 200; i++) begin
                s_valid = ($urandom_range(0, 99) < pct);
                magni = 16'($urandom);
                phase = 16'($urandom);
                cw_phase_increment = $urandom;
                cw_phase_increment_valid = ($urandom_range(0, 99) < 3);
                step();
                if ($urandom_range(0, 999) == 0) apply_reset();
            end
            cw_phase_increment_valid = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iq_mod_top.md
IQ_MOD_TOP -- requirements
Module: iq_mod_top

Interface
REQ-001 Parameter HOLD_CYCLES, default 50, meaning clocks each input sample is held (50 MHz / 50 = 1 MS/s); legal range 4..65535.
REQ-002 sys_clk  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-003 sys_rstn  input  1  reset; asynchronous, active-low.
REQ-004 s_valid  input  1  input sample valid.
REQ-005 s_ready  output  1  block can accept a sample.
REQ-006 magni  input  16  unsigned magnitude; 65535 = full scale.
REQ-007 phase  input  16  signed phase; LSB = pi/32768, 0x8000 = -pi.
REQ-008 cw_phase_increment  input  32  unsigned carrier tuning word, K = f0*2^32/50 MHz.
REQ-009 cw_phase_increment_valid  input  1  tuning word load strobe.
REQ-010 dac_data  output  16  signed modulated carrier.
REQ-011 dac_valid  output  1  dac_data valid.
REQ-012 underrun  output  1  one-cycle pulse when the hold period expires with no buffered sample.

Function
REQ-013 Output SHALL be dac_data = magni * cos(2*pi*acc/2^32 + pi*phase/32768), acc being the 32-bit carrier phase accumulator.
REQ-014 Input path SHALL be a one-entry buffer plus an active register; s_ready = !buf_full, registered.
REQ-015 Transfer SHALL occur when s_valid && s_ready; the sample is written to the buffer, never directly to the active register.
REQ-016 A hold counter SHALL count HOLD_CYCLES-1 down to 0; at 0 it reloads, and the buffer, if full, moves to the active register and clears.
REQ-017 At hold expiry with an empty buffer, the active magnitude SHALL become 0, the active phase SHALL be retained, and underrun SHALL pulse for one cycle.
REQ-018 A transfer coinciding with hold expiry on an empty buffer SHALL fill the buffer and SHALL still cause underrun; the sample becomes active at the next expiry.
REQ-019 The hold counter SHALL run only after the first sample has become active; before that, dac_valid = 0.
REQ-020 The accumulator SHALL advance by the latched tuning word every cycle and wrap modulo 2^32.
REQ-021 The tuning word SHALL be latched on cw_phase_increment_valid and used from the next cycle.
REQ-022 Retuning SHALL NOT reset the accumulator, so carrier phase stays continuous.
REQ-023 Pipeline stage 1 SHALL register psum = acc[31:16] + active phase, modulo 2^16.
REQ-024 Pipeline stage 2 SHALL register cosv = LUT[psum[15:6]], where entry k = round(32767*cos(2*pi*k/1024)), signed Q1.15.
REQ-025 Pipeline stage 3 SHALL register the signed 33-bit product cosv * {0,magni}.
REQ-026 Pipeline stage 4 SHALL register dac_data = (product + 2^15) >>> 16, saturated to [-32767, +32767].
REQ-027 Latency from an active-register update to the corresponding dac_data SHALL be 4 clocks.
REQ-028 dac_valid SHALL rise 4 clocks after the first sample becomes active and stay high until reset.

Reset
REQ-029 On sys_rstn low, these SHALL clear immediately: acc, tuning word, buffer, active register, hold counter, and pipeline registers.
REQ-030 Outputs in reset SHALL be s_ready 0, dac_data 0, dac_valid 0, underrun 0.
REQ-031 s_ready SHALL rise on the first clock after reset release.
REQ-032 Reset asserted mid-operation SHALL discard buffered and active samples; no partial output appears after release.

Structure
REQ-033 A shared package SHALL hold the LUT depth (1024), the data widths (16), the phase-accumulator width (32) and the saturation limit (32767).
REQ-034 The cosine table SHALL be a sub-module iq_mod_cos_lut: 10-bit address in, registered 16-bit signed out, 1-clock latency.

Verification
REQ-035 Scenario: K = 0, one sample magni 65535, phase 0 -> dac_data = 32767 steady; K = 0, phase 0x8000 -> -32767.
REQ-036 Scenario: K = 0x40000000, magni 65535, phase 0 -> repeating 32767, 0, -32767, 0 from the first valid output.
REQ-037 Scenario: K = 0, magni 32768, phase 0x4000 -> dac_data = 0; phase 0x0000 -> 16384.
REQ-038 Scenario: HOLD_CYCLES = 4, continuous s_valid -> one acceptance per 4 clocks, s_ready low while buffer full, no underrun.
REQ-039 Scenario: single sample then s_valid low -> underrun pulses exactly once, HOLD_CYCLES clocks after activation; dac_data reaches 0 four clocks later.
REQ-040 Scenario: K changed 0x40000000 -> 0x20000000 mid-stream -> acc continues from its current value with no phase jump; sys_rstn pulsed mid-hold -> all outputs 0 and s_ready 0 during reset.
